// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers x/y from active-low VGA syncs and validates line/frame timing before asserting lock
module vga_sync_decoder #(
  parameter int H_TOTAL      = 800,
  parameter int H_ACTIVE     = 640,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_WIDTH = 96,
  parameter int V_TOTAL      = 525,
  parameter int V_ACTIVE     = 480,
  parameter int V_SYNC_START = 490,
  parameter int LOCK_FRAMES  = 2,
  parameter int TIMEOUT      = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       de,
  output logic       locked,
  output logic       h_err,
  output logic       v_err,
  output logic [9:0] line_period
);
  localparam logic [1:0] SEARCH = 2'd0, TRACK = 2'd1, LOCKED = 2'd2;
  localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST = 10'(V_TOTAL - 1);
  logic        r_hs_q, r_hs_d, r_vs_q, r_vs_d;
  logic [9:0]  r_x, r_y, r_width, r_lines, r_line_period;
  logic [10:0] r_period;
  logic [1:0]  r_state;
  logic [7:0]  r_good;
  logic        r_skip, r_started, r_frame_bad, r_h_err, r_v_err;
  logic        w_hs_fall, w_hs_rise, w_vs_fall, w_x_wrap;
  logic        w_period_bad, w_width_bad, w_timeout, w_count_bad;
  logic        w_h_bad, w_v_bad, w_frame_ok;
  logic [9:0]  w_lines_now;
  logic [7:0]  w_good_next;

  assign w_hs_fall    = r_hs_d & ~r_hs_q;
  assign w_hs_rise    = ~r_hs_d & r_hs_q;
  assign w_vs_fall    = r_vs_d & ~r_vs_q;
  assign w_x_wrap     = !w_hs_fall && r_x == X_LAST;
  // a line ending on the same cycle as vsync falls belongs to the frame being closed
  assign w_lines_now  = (w_hs_fall && r_lines != 10'h3FF) ? r_lines + 10'd1 : r_lines;
  assign w_period_bad = w_hs_fall && r_period != 11'(H_TOTAL) && !(r_state == TRACK && r_skip);
  assign w_width_bad  = w_hs_rise && r_width != 10'(H_SYNC_WIDTH);
  assign w_timeout    = r_period > 11'(TIMEOUT);
  assign w_count_bad  = w_lines_now != 10'(V_TOTAL);
  assign w_h_bad      = r_state != SEARCH && (w_period_bad || w_width_bad || w_timeout);
  assign w_v_bad      = w_vs_fall && w_count_bad && (r_state == LOCKED || (r_state == TRACK && r_started));
  assign w_frame_ok   = !r_frame_bad && !w_period_bad && !w_width_bad && !w_count_bad;
  assign w_good_next  = r_good + 8'd1;

  assign x           = r_x;
  assign y           = r_y;
  assign locked      = r_state == LOCKED;
  assign de          = locked && r_x < 10'(H_ACTIVE) && r_y < 10'(V_ACTIVE);
  assign h_err       = r_h_err;
  assign v_err       = r_v_err;
  assign line_period = r_line_period;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hs_q        <= 1'b1;
      r_hs_d        <= 1'b1;
      r_vs_q        <= 1'b1;
      r_vs_d        <= 1'b1;
      r_x           <= '0;
      r_y           <= '0;
      r_period      <= '0;
      r_width       <= '0;
      r_lines       <= '0;
      r_line_period <= '0;
    end else begin
      r_hs_q        <= hsync_in;
      r_hs_d        <= r_hs_q;
      r_vs_q        <= vsync_in;
      r_vs_d        <= r_vs_q;
      r_x           <= w_hs_fall ? 10'(H_SYNC_START) : (r_x == X_LAST ? 10'd0 : r_x + 10'd1);
      r_y           <= w_vs_fall ? 10'(V_SYNC_START) : (w_x_wrap ? (r_y == Y_LAST ? 10'd0 : r_y + 10'd1) : r_y);
      r_period      <= w_hs_fall ? 11'd1 : (r_period == 11'h7FF ? r_period : r_period + 11'd1);
      r_width       <= r_hs_q ? 10'd0 : (r_width == 10'h3FF ? r_width : r_width + 10'd1);
      r_lines       <= w_vs_fall ? 10'd0 : w_lines_now;
      r_line_period <= w_hs_fall ? (r_period[10] ? 10'h3FF : r_period[9:0]) : r_line_period;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= SEARCH;
      r_good      <= '0;
      r_skip      <= 1'b0;
      r_started   <= 1'b0;
      r_frame_bad <= 1'b0;
      r_h_err     <= 1'b0;
      r_v_err     <= 1'b0;
    end else begin
      r_h_err <= w_h_bad;
      r_v_err <= w_v_bad;
      if (r_state == SEARCH) begin
        if (w_hs_fall) begin
          r_state     <= TRACK;
          r_good      <= '0;
          r_skip      <= 1'b1;
          r_started   <= 1'b0;
          r_frame_bad <= 1'b0;
        end
      end else if (w_timeout || (r_state == LOCKED && (w_h_bad || w_v_bad))) begin
        r_state <= SEARCH;
      end else if (r_state == TRACK) begin
        if (w_hs_fall)
          r_skip <= 1'b0;
        // the first vsync after entry only opens the first measured frame
        if (w_vs_fall) begin
          r_started   <= 1'b1;
          r_frame_bad <= 1'b0;
          if (r_started && w_frame_ok) begin
            r_good <= w_good_next;
            if (w_good_next >= 8'(LOCK_FRAMES))
              r_state <= LOCKED;
          end else if (r_started) begin
            r_good <= '0;
          end
        end else if (w_h_bad) begin
          r_frame_bad <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: scoreboard bench on a reduced 40x12 raster covering lock, error pulses, timeout and reset
module tb_vga_sync_decoder;
  localparam int HT = 40, HA = 32, HS = 33, HW = 4, VT = 12, VA = 8, VS = 9;
  localparam byte KH = 8'h48, KV = 8'h56, KL = 8'h4C, KU = 8'h55, KP = 8'h50, KW = 8'h57;
  typedef struct {int cyc; byte kind; int val;} ev_t;
  logic clk = 0, reset = 1, hsync_in = 1, vsync_in = 1;
  logic [9:0] x, y, line_period;
  logic de, locked, h_err, v_err;
  ev_t evq[$], posq[$];
  int cyc = 0, errors = 0, checks = 0, de_cnt = 0, last_fall = 0;
  int bad_len = -1, bad_w = -1, h_fall = -1, h_rise = -1;
  bit exp_v = 0, exp_l = 0, chk_xy = 0, chk_lp = 0, cnt_de = 0, prev_locked = 0;

  vga_sync_decoder #(
    .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HS), .H_SYNC_WIDTH(HW),
    .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VS), .LOCK_FRAMES(2), .TIMEOUT(1023)
  ) dut (
    .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .x(x), .y(y), .de(de), .locked(locked), .h_err(h_err), .v_err(v_err),
    .line_period(line_period)
  );

  always #5 clk = ~clk;

  task automatic push(int c, byte k, int v, bit pos);
    ev_t e;
    e.cyc = c;
    e.kind = k;
    e.val = v;
    if (pos) posq.push_back(e);
    else evq.push_back(e);
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic obs(byte k);
    ev_t e;
    e.cyc = -1;
    e.kind = 8'h3F;
    e.val = 0;
    if (evq.size() > 0) e = evq.pop_front();
    checks++;
    assert (e.kind === k && e.cyc === cyc) else begin
      errors++;
      $error("FAIL event_%c: observed %c@%0d expected %c@%0d", k, k, cyc, e.kind, e.cyc);
    end
  endtask

  task automatic tick();
    ev_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (cnt_de) de_cnt += int'(de);
    if (h_err) obs(KH);
    if (v_err) obs(KV);
    if (locked && !prev_locked) obs(KL);
    if (!locked && prev_locked) obs(KU);
    prev_locked = locked;
    while (posq.size() > 0 && posq[0].cyc == cyc) begin
      e = posq.pop_front();
      chk(e.kind == KP ? "xy" : "line_period", e.kind == KP ? {12'd0, y, x} : {22'd0, line_period}, e.val);
    end
  endtask

  task automatic drive(bit hs, bit vs);
    hsync_in = hs;
    vsync_in = vs;
    tick();
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_x"}, {22'd0, x}, 0);
    chk({tag, "_y"}, {22'd0, y}, 0);
    chk({tag, "_de"}, {31'd0, de}, 0);
    chk({tag, "_locked"}, {31'd0, locked}, 0);
    chk({tag, "_h_err"}, {31'd0, h_err}, 0);
    chk({tag, "_v_err"}, {31'd0, v_err}, 0);
    chk({tag, "_line_period"}, {22'd0, line_period}, 0);
  endtask

  // inputs set while cyc==k reach the DUT's edge detectors so that responses are visible at cyc k+2
  task automatic frame(int nlines);
    for (int l = 0; l < nlines; l++) begin
      int len, w;
      len = (l == bad_len) ? HT + 1 : HT;
      w = (l == bad_w) ? HW - 1 : HW;
      for (int i = 0; i < len; i++) begin
        if (i == 0 && l == VS) begin
          if (exp_v) begin
            push(cyc + 2, KV, 0, 0);
            push(cyc + 2, KU, 0, 0);
          end
          if (exp_l) push(cyc + 2, KL, 0, 0);
        end
        if (i == 0 && chk_xy) push(cyc + 2, KP, l * 1024, 1);
        if (i == HS) begin
          last_fall = cyc;
          if (l == h_fall) begin
            push(cyc + 2, KH, 0, 0);
            push(cyc + 2, KU, 0, 0);
          end
          if (chk_lp && l < 2) push(cyc + 2, KW, l == 0 ? 1023 : HT, 1);
        end
        if (i == HS + w && l == h_rise) begin
          push(cyc + 2, KH, 0, 0);
          push(cyc + 2, KU, 0, 0);
        end
        drive(!(i >= HS && i < HS + w), !(l == VS || l == VS + 1));
      end
    end
    bad_len = -1;
    bad_w = -1;
    h_fall = -1;
    h_rise = -1;
    exp_v = 0;
    exp_l = 0;
    chk_xy = 0;
    chk_lp = 0;
  endtask

  initial begin
    repeat (2) tick();
    chk_zero("reset");
    reset = 0;
    frame(VT);
    frame(VT);
    exp_l = 1;
    frame(VT);
    cnt_de = 1;
    chk_xy = 1;
    frame(VT);
    cnt_de = 0;
    chk("de_per_frame", de_cnt, HA * VA);
    bad_len = 3;
    h_fall = 4;
    frame(VT);
    frame(VT);
    exp_l = 1;
    frame(VT);
    bad_w = 2;
    h_rise = 2;
    frame(VT);
    frame(VT);
    exp_l = 1;
    frame(VT);
    frame(VT - 1);
    exp_v = 1;
    frame(VT);
    frame(VT);
    frame(VT);
    exp_l = 1;
    frame(VT);
    push(last_fall + 1026, KH, 0, 0);
    push(last_fall + 1026, KU, 0, 0);
    repeat (2000) drive(1, 1);
    chk_lp = 1;
    frame(VT);
    frame(VT);
    exp_l = 1;
    frame(VT);
    frame(5);
    repeat (20) drive(1, 1);
    reset = 1;
    #1;
    chk_zero("mid_reset");
    prev_locked = 0;
    repeat (2) tick();
    reset = 0;
    frame(VT);
    frame(VT);
    exp_l = 1;
    frame(VT);
    repeat (4) tick();
    chk("events_pending", evq.size(), 0);
    chk("samples_pending", posq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
